// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller: size codes, lane masks,
// requester indices and the load-extension helper.
package ram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_LO   = 4'b0011;
  localparam logic [3:0] SEL_HI   = 4'b1100;
  localparam logic [3:0] SEL_ALL  = 4'b1111;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  // Widen a byte (half = 0, value in v[7:0]) or halfword to 32 bits.
  function automatic logic [31:0] extend(input logic [15:0] v, input logic half,
                                         input logic sext);
    logic fill;
    fill   = sext & (half ? v[15] : v[7]);
    extend = half ? {{16{fill}}, v} : {{24{fill}}, v[7:0]};
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Requester-side bus of the RAM access controller; one instance per requester.
interface ram_access_ctrl_if
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              gnt;
  logic              we;
  size_e             size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_access_ctrl_lane_align.sv
// Combinational lane steering: byte selects and replicated store data for the
// RAM, extracted/extended load data, and alignment/size error detection.
module mem_lane_align
  import ram_access_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        sext,
  output logic [3:0]  sel,
  output logic [31:0] din,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [3:0]  raw_sel_s;
  logic [31:0] raw_rdata_s;

  // Pick the addressed byte of the read word.
  always_comb begin
    case (offset)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      2'd3:    byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  assign half_s = offset[1] ? rword[31:16] : rword[15:0];

  // Size-dependent lane mask, store replication, load extension and error.
  always_comb begin
    raw_sel_s   = SEL_NONE;
    din         = 32'h0000_0000;
    raw_rdata_s = 32'h0000_0000;
    err         = 1'b0;
    case (size)
      SZ_BYTE: begin
        raw_sel_s   = SEL_B0 << offset;
        din         = {4{wdata[7:0]}};
        raw_rdata_s = extend({8'h00, byte_s}, 1'b0, sext);
      end
      SZ_HALF: begin
        err         = offset[0];
        raw_sel_s   = offset[1] ? SEL_HI : SEL_LO;
        din         = {2{wdata[15:0]}};
        raw_rdata_s = extend(half_s, 1'b1, sext);
      end
      SZ_WORD: begin
        err         = (offset != 2'b00);
        raw_sel_s   = SEL_ALL;
        din         = wdata;
        raw_rdata_s = rword;
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  // Errored accesses must not touch any lane nor return data.
  assign sel   = err ? SEL_NONE : raw_sel_s;
  assign rdata = err ? 32'h0000_0000 : raw_rdata_s;

endmodule

// File: rtl/ram_access_ctrl.sv
// Two-requester round-robin front end for a single-port word RAM with sized,
// byte-addressed accesses and a fixed one-cycle registered response.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int   ADDR_W   = 12,
  parameter logic RR_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  ram_access_ctrl_if.slave  m0,
  ram_access_ctrl_if.slave  m1,
  output logic              ram_we,
  output logic              ram_ld,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  logic              ptr_r;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              acc_s;
  logic              we_s;
  size_e             size_s;
  logic              sext_s;
  logic [ADDR_W-1:0] addr_s;
  logic [31:0]       wdata_s;
  logic [3:0]        sel_s;
  logic [31:0]       din_s;
  logic [31:0]       ext_s;
  logic              err_s;

  logic              r0_valid_r, r1_valid_r;
  logic              r0_err_r,   r1_err_r;
  logic [31:0]       r0_data_r,  r1_data_r;

  // The pointer only matters when both request; a lone requester always wins.
  assign gnt0_s = !rst && m0.req && (!m1.req || (ptr_r == REQ_M0));
  assign gnt1_s = !rst && m1.req && (!m0.req || (ptr_r == REQ_M1));
  assign acc_s  = gnt0_s || gnt1_s;

  assign m0.gnt = gnt0_s;
  assign m1.gnt = gnt1_s;

  assign we_s    = gnt1_s ? m1.we    : m0.we;
  assign size_s  = gnt1_s ? m1.size  : m0.size;
  assign sext_s  = gnt1_s ? m1.sext  : m0.sext;
  assign addr_s  = gnt1_s ? m1.addr  : m0.addr;
  assign wdata_s = gnt1_s ? m1.wdata : m0.wdata;

  mem_lane_align u_align (
    .size   (size_s),
    .offset (addr_s[1:0]),
    .wdata  (wdata_s),
    .rword  (ram_dout),
    .sext   (sext_s),
    .sel    (sel_s),
    .din    (din_s),
    .rdata  (ext_s),
    .err    (err_s)
  );

  assign ram_we   = acc_s && we_s && !err_s;
  assign ram_ld   = acc_s && !we_s && !err_s;
  assign ram_sel  = (acc_s && !err_s) ? sel_s : SEL_NONE;
  assign ram_addr = acc_s ? addr_s[ADDR_W-1:2] : {(ADDR_W-2){1'b0}};
  assign ram_din  = acc_s ? din_s : 32'h0000_0000;

  // Round-robin pointer and per-requester response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= RR_RESET;
      r0_valid_r <= 1'b0;
      r1_valid_r <= 1'b0;
      r0_err_r   <= 1'b0;
      r1_err_r   <= 1'b0;
      r0_data_r  <= 32'h0000_0000;
      r1_data_r  <= 32'h0000_0000;
    end else begin
      if (acc_s) begin
        ptr_r <= ~gnt1_s;
      end else begin
        ptr_r <= ptr_r;
      end
      r0_valid_r <= gnt0_s;
      r1_valid_r <= gnt1_s;
      r0_err_r   <= gnt0_s && err_s;
      r1_err_r   <= gnt1_s && err_s;
      r0_data_r  <= (gnt0_s && !we_s && !err_s) ? ext_s : 32'h0000_0000;
      r1_data_r  <= (gnt1_s && !we_s && !err_s) ? ext_s : 32'h0000_0000;
    end
  end

  // Reset masks the response immediately so a pending pulse never appears.
  assign m0.rvalid = r0_valid_r && !rst;
  assign m1.rvalid = r1_valid_r && !rst;
  assign m0.err    = r0_err_r && !rst;
  assign m1.err    = r1_err_r && !rst;
  assign m0.rdata  = rst ? 32'h0000_0000 : r0_data_r;
  assign m1.rdata  = rst ? 32'h0000_0000 : r1_data_r;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench: directed vectors, multi-cycle corner sequences and a
// randomized run against a byte-array memory model.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  localparam int   ADDR_W   = 12;
  localparam logic RR_RESET = 1'b0;

  logic        clk;
  logic        rst;
  logic        ram_we, ram_ld;
  logic [3:0]  ram_sel;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  ram_access_ctrl_if #(.ADDR_W(ADDR_W)) m0_if ();
  ram_access_ctrl_if #(.ADDR_W(ADDR_W)) m1_if ();

  ram_access_ctrl #(.ADDR_W(ADDR_W), .RR_RESET(RR_RESET)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .ram_we   (ram_we),
    .ram_ld   (ram_ld),
    .ram_sel  (ram_sel),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical RAM: asynchronous read, byte-lane write at the clock edge.
  logic [31:0] mem [1024];
  assign ram_dout = ram_ld ? mem[ram_addr] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
    end
  end

  // Reference model: flat byte memory plus the requester holding priority.
  logic [7:0] ref_mem [4096];
  logic       prio;

  int checks = 0;
  int errors = 0;

  logic        last_g0, last_g1, last_err;
  logic [3:0]  last_sel;
  logic [9:0]  last_addr;
  logic [31:0] last_din, last_rdata;

  typedef struct {
    logic        port;
    logic        we;
    size_e       size;
    logic        sext;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] din;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.size = SZ_WORD; m0_if.sext = 1'b0;
    m0_if.addr = 12'h000; m0_if.wdata = 32'h0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.size = SZ_WORD; m1_if.sext = 1'b0;
    m1_if.addr = 12'h000; m1_if.wdata = 32'h0;
  endtask

  task automatic drive(input logic port, input logic we, input size_e sz, input logic sx,
                       input logic [11:0] a, input logic [31:0] wd);
    if (port) begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.size = sz; m1_if.sext = sx;
      m1_if.addr = a; m1_if.wdata = wd;
    end else begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.size = sz; m0_if.sext = sx;
      m0_if.addr = a; m0_if.wdata = wd;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m0_gnt"},    32'(m0_if.gnt),    32'h0);
    chk({tag, "_m1_gnt"},    32'(m1_if.gnt),    32'h0);
    chk({tag, "_m0_rvalid"}, 32'(m0_if.rvalid), 32'h0);
    chk({tag, "_m1_rvalid"}, 32'(m1_if.rvalid), 32'h0);
    chk({tag, "_m0_err"},    32'(m0_if.err),    32'h0);
    chk({tag, "_m1_err"},    32'(m1_if.err),    32'h0);
    chk({tag, "_m0_rdata"},  m0_if.rdata,       32'h0);
    chk({tag, "_m1_rdata"},  m1_if.rdata,       32'h0);
    chk({tag, "_ram_we"},    32'(ram_we),       32'h0);
    chk({tag, "_ram_ld"},    32'(ram_ld),       32'h0);
    chk({tag, "_ram_sel"},   32'(ram_sel),      32'h0);
    chk({tag, "_ram_addr"},  32'(ram_addr),     32'h0);
    chk({tag, "_ram_din"},   ram_din,           32'h0);
  endtask

  // Called 1 time unit after a rising edge with inputs already driven; returns
  // 1 time unit after the next rising edge with the response checked.
  task automatic step();
    logic        r0, r1, g0, g1, acc, idx, we, sx, err, rv;
    size_e       sz;
    logic [11:0] a;
    logic [31:0] wd, val, din, act;
    logic [3:0]  sel;
    int          nb;
    #2;
    r0 = m0_if.req; r1 = m1_if.req;
    g0 = r0 && (!r1 || prio == 1'b0);
    g1 = r1 && (!r0 || prio == 1'b1);
    chk("m0_gnt", 32'(m0_if.gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_if.gnt), 32'(g1));
    last_g0 = m0_if.gnt; last_g1 = m1_if.gnt;
    acc = g0 || g1; idx = g1;
    we  = idx ? m1_if.we    : m0_if.we;
    sz  = idx ? m1_if.size  : m0_if.size;
    sx  = idx ? m1_if.sext  : m0_if.sext;
    a   = idx ? m1_if.addr  : m0_if.addr;
    wd  = idx ? m1_if.wdata : m0_if.wdata;
    nb  = (sz == SZ_RSVD) ? 0 : (1 << int'(sz));
    err = (nb == 0) || ((int'(a) % nb) != 0);
    val = 32'h0; sel = 4'h0; din = 32'h0;
    if (acc && !err) begin
      for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (sx && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
      sel = 4'(((1 << nb) - 1) << (int'(a) % 4));
      for (int i = 0; i < 4; i++) din[8*i +: 8] = wd[8*(i % nb) +: 8];
    end
    if (we) val = 32'h0;
    chk("ram_we",  32'(ram_we),  32'(acc && we && !err));
    chk("ram_ld",  32'(ram_ld),  32'(acc && !we && !err));
    chk("ram_sel", 32'(ram_sel), 32'(sel));
    if (acc) chk("ram_addr", 32'(ram_addr), 32'(a >> 2));
    if (acc && we && !err) chk("ram_din", ram_din, din);
    last_sel = ram_sel; last_din = ram_din; last_addr = ram_addr;
    if (acc && we && !err)
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    if (acc) prio = ~idx;
    @(posedge clk); #1;
    chk("m0_rvalid", 32'(m0_if.rvalid), 32'(acc && !idx));
    chk("m1_rvalid", 32'(m1_if.rvalid), 32'(acc && idx));
    if (acc) begin
      act = idx ? m1_if.rdata : m0_if.rdata;
      rv  = idx ? m1_if.err   : m0_if.err;
      chk("rdata", act, val);
      chk("err", 32'(rv), 32'(err));
      last_rdata = act; last_err = rv;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    m0_if.req = 1'b1; m1_if.req = 1'b1;
    #2;
    chk("rst_m0_gnt", 32'(m0_if.gnt), 32'h0);
    chk("rst_m1_gnt", 32'(m1_if.gnt), 32'h0);
    idle();
    @(posedge clk); #1;
    chk_all_zero("rst");
    rst = 1'b0;
    prio = RR_RESET;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    prio = RR_RESET;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

    vecs[0]  = '{1'b0, 1'b1, SZ_WORD, 1'b0, 12'h010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0,        4'b1111, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, SZ_BYTE, 1'b1, 12'h013, 32'h0,        4'b1000, 32'h0,        1'b0, 32'hFFFFFFDE};
    vecs[3]  = '{1'b0, 1'b0, SZ_BYTE, 1'b0, 12'h013, 32'h0,        4'b1000, 32'h0,        1'b0, 32'h000000DE};
    vecs[4]  = '{1'b0, 1'b0, SZ_HALF, 1'b1, 12'h010, 32'h0,        4'b0011, 32'h0,        1'b0, 32'hFFFFBEEF};
    vecs[5]  = '{1'b0, 1'b0, SZ_HALF, 1'b0, 12'h012, 32'h0,        4'b1100, 32'h0,        1'b0, 32'h0000DEAD};
    vecs[6]  = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 12'h011, 32'h00000055, 4'b0010, 32'h55555555, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0,        4'b1111, 32'h0,        1'b0, 32'hDEAD55EF};
    vecs[8]  = '{1'b0, 1'b1, SZ_HALF, 1'b0, 12'h011, 32'h00001234, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 12'h012, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b0, SZ_RSVD, 1'b0, 12'h010, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b1, SZ_RSVD, 1'b0, 12'h010, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0,        4'b1111, 32'h0,        1'b0, 32'hDEAD55EF};
    vecs[13] = '{1'b1, 1'b0, SZ_BYTE, 1'b0, 12'h010, 32'h0,        4'b0001, 32'h0,        1'b0, 32'h000000EF};
    vecs[14] = '{1'b1, 1'b0, SZ_HALF, 1'b1, 12'h012, 32'h0,        4'b1100, 32'h0,        1'b0, 32'hFFFFDEAD};

    do_reset();

    // Directed vectors, one requester at a time, back to back.
    for (int v = 0; v < 15; v++) begin
      idle();
      drive(vecs[v].port, vecs[v].we, vecs[v].size, vecs[v].sext, vecs[v].addr, vecs[v].wdata);
      step();
      chk($sformatf("vec%0d_sel", v), 32'(last_sel), 32'(vecs[v].sel));
      if (vecs[v].we && !vecs[v].err) chk($sformatf("vec%0d_din", v), last_din, vecs[v].din);
      if (v == 0) chk("vec0_ram_addr", 32'(last_addr), 32'd4);
      chk($sformatf("vec%0d_rdata", v), last_rdata, vecs[v].rdata);
      chk($sformatf("vec%0d_err", v), 32'(last_err), 32'(vecs[v].err));
    end
    idle();
    chk("mem_word4_final", mem[4], 32'hDEAD55EF);

    // Both requesters held for four cycles straight out of reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0);
      drive(1'b1, 1'b0, SZ_BYTE, 1'b0, 12'h011, 32'h0);
      step();
      chk($sformatf("alt%0d_m0_gnt", i), 32'(last_g0), 32'((i % 2) == 0));
      chk($sformatf("alt%0d_m1_gnt", i), 32'(last_g1), 32'((i % 2) == 1));
    end
    idle();

    // Reset in the cycle after an accepted m1 load squashes its response.
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0);
    #2;
    chk("mid_m1_gnt", 32'(m1_if.gnt), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    m0_if.req = 1'b1;
    #1;
    chk_all_zero("mid");
    @(posedge clk); #1;
    rst = 1'b0;
    prio = RR_RESET;
    idle();
    step();

    // Pointer returns to its reset value: leave it on m1, reset, then contend.
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 12'h000, 32'h0);
    step();
    do_reset();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0);
    step();
    chk("ptr_reset_m0_gnt", 32'(last_g0), 32'(RR_RESET == REQ_M0));
    chk("ptr_reset_m1_gnt", 32'(last_g1), 32'(RR_RESET == REQ_M1));
    idle();

    // Randomized traffic on a small address window so accesses collide.
    for (int n = 0; n < 400; n++) begin
      m0_if.req   = ($urandom_range(0, 9) < 7);
      m0_if.we    = 1'($urandom_range(0, 1));
      m0_if.size  = size_e'($urandom_range(0, 3));
      m0_if.sext  = 1'($urandom_range(0, 1));
      m0_if.addr  = 12'($urandom_range(0, 47));
      m0_if.wdata = $urandom;
      m1_if.req   = ($urandom_range(0, 9) < 6);
      m1_if.we    = 1'($urandom_range(0, 1));
      m1_if.size  = size_e'($urandom_range(0, 3));
      m1_if.sext  = 1'($urandom_range(0, 1));
      m1_if.addr  = 12'($urandom_range(0, 47));
      m1_if.wdata = $urandom;
      step();
    end
    idle();
    for (int w = 0; w < 12; w++)
      chk($sformatf("mem_word%0d", w), mem[w],
          {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Sits between two memory requesters and the single-port data RAM (10-bit word address, 4-bit byte select, write enable, load enable).
  - Port 0: CPU load/store unit.
  - Port 1: debug/program loader.
- Arbitrates round-robin and converts byte-addressed, sized requests into word address, byte lanes and lane-aligned store data.
- Returns registered, sign- or zero-extended load data one cycle after acceptance.
- Flags misaligned and reserved-size accesses as errors; errored accesses never touch the RAM.

Parameters:
- ADDR_W, 12, byte address width; word address is ADDR_W-2 bits (10 for the 1024-word RAM).
- RR_RESET, 0, requester holding priority after reset.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  request valid.
- m0_gnt, m1_gnt  out  1  combinational accept; a transfer occurs when req && gnt at the clock edge.
- m0_we, m1_we  in  1  1 = store, 0 = load.
- m0_size, m1_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- m0_signed, m1_signed  in  1  sign-extend load (byte/half only).
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wdata, m1_wdata  in  32  store data, right-justified.
- m0_rvalid, m1_rvalid  out  1  one-cycle response pulse.
- m0_rdata, m1_rdata  out  32  extended load data; 0 for stores and errors.
- m0_err, m1_err  out  1  qualified by rvalid.
- ram_we  out  1  RAM write enable.
- ram_ld  out  1  RAM load enable.
- ram_sel  out  4  RAM byte lane select.
- ram_addr  out  ADDR_W-2  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data; undefined when ram_ld = 0.

Behaviour:
- Reset:
  - All gnt, rvalid and err outputs are 0; rdata is 0.
  - ram_we, ram_ld are 0; ram_sel, ram_addr, ram_din are 0.
  - The round-robin pointer is set to RR_RESET.
  - Any response pending at reset is discarded and never pulses.
- Arbitration, combinational from current inputs and the registered pointer:
  - Only one request: it is granted.
  - Both requesting: the requester named by the pointer is granted.
  - After any accepted transfer the pointer moves to the non-granted requester. With no transfer it holds.
  - At most one gnt per cycle. gnt is 0 while rst = 1.
- Decode of the granted request:
  - word address = addr[ADDR_W-1:2]; byte offset = addr[1:0].
  - Byte: ram_sel = 0001 << offset; ram_din = wdata[7:0] replicated into all 4 lanes.
  - Half: offset must be 0 or 2. ram_sel = 0011 (offset 0) or 1100 (offset 2); ram_din = wdata[15:0] replicated in both halves.
  - Word: offset must be 0. ram_sel = 1111; ram_din = wdata.
  - Error cases: size 11, or a misaligned half/word.
- RAM drive, during the accept cycle only:
  - ram_we = we && !error. The write commits at the accepting edge.
  - ram_ld = !we && !error.
  - With no accepted transfer or an error: ram_we = 0, ram_ld = 0, ram_sel = 0.
- Response:
  - At the accepting edge the controller registers the target requester, error, size, signed and offset, plus the extracted load data computed from ram_dout in that cycle.
  - The next cycle: target rvalid = 1 for exactly one cycle, with rdata and err valid in that same cycle. Latency is fixed at 1.
  - Extraction: the byte or half is selected by offset, then sign-extended when signed = 1, else zero-extended. Word loads ignore signed.
- Back-to-back operation:
  - A requester may hold req high across consecutive cycles; each cycle with gnt is a new transfer.
  - A response and a new accept may occur in the same cycle, including for the same requester.
  - Throughput is one transfer per cycle.
- Read-after-write to the same word in consecutive cycles returns the new data (the RAM write is visible at the next cycle).
- Reset asserted mid-stream overrides all other events in that cycle.

Decomposition:
- Shared package holds:
  - Size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11.
  - Lane-select constants.
  - Requester index constants.
- One natural sub-module, mem_lane_align (combinational):
  - Inputs: size, offset, wdata, rdata-word, signed.
  - Outputs: sel, din, extracted rdata, error.
- The arbiter, pointer and response register stay in the top module.

Test Plan:
- After reset: m0 word store addr 0x010 data 0xDEADBEEF, then m0 word load addr 0x010.
  - Store cycle: ram_sel = 1111, ram_addr = 4.
  - Load: m0_rvalid pulses exactly 1 cycle later with rdata 0xDEADBEEF, err = 0.
- Byte/half extraction on word 4 = 0xDEADBEEF:
  - Signed byte load at 0x013 → 0xFFFFFFDE; unsigned → 0x000000DE.
  - Signed half at 0x010 → 0xFFFFBEEF; unsigned half at 0x012 → 0x0000DEAD.
- Byte store 0x55 at 0x011, then word load at 0x010.
  - Store cycle: ram_sel = 0010, ram_din = 0x55555555.
  - Load → 0xDEAD55EF.
- m0 and m1 both hold req for 4 cycles from reset.
  - Grants alternate m0, m1, m0, m1.
  - Each requester sees its rvalid the cycle after its grant; never both gnt in one cycle.
- Half store at 0x011, word load at 0x012, and any size-11 access:
  - Each is granted with ram_we = 0, ram_ld = 0, ram_sel = 0.
  - Next cycle rvalid = 1, err = 1, rdata = 0; memory is unchanged.
- Assert rst in the cycle after an accepted m1 load: m1_rvalid stays 0, the pointer returns to RR_RESET, and all outputs read 0.
